// File: rtl/video_burst_reader_pkg.sv
// Shared state encodings and constants for the video row-preload read adapter.
package video_burst_reader_pkg;

    typedef enum logic [1:0] {
        VBR_IDLE  = 2'd0,
        VBR_ISSUE = 2'd1,
        VBR_WAIT  = 2'd2
    } vbr_state_e;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int PAGE_WORDS_DEF = 256;
    localparam int LEN_WIDTH      = 9;

endpackage

// File: rtl/video_burst_reader_if.sv
// Request/stream/SDRAM-command bundle; master is the adapter, slave is its environment.
interface video_burst_reader_if #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32
);
    logic                  rd_request;
    logic [ADDR_WIDTH-1:0] rd_address;
    logic [8:0]            rd_burst_length;
    logic                  rd_available;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  busy;
    logic                  overrun;

    logic                  sd_req;
    logic                  sd_ack;
    logic [ADDR_WIDTH-1:0] sd_address;
    logic [8:0]            sd_length;
    logic                  sd_data_valid;
    logic [DATA_WIDTH-1:0] sd_data;

    modport master (
        input  rd_request, rd_address, rd_burst_length,
        input  sd_ack, sd_data_valid, sd_data,
        output rd_available, rd_data, busy, overrun,
        output sd_req, sd_address, sd_length
    );

    modport slave (
        output rd_request, rd_address, rd_burst_length,
        output sd_ack, sd_data_valid, sd_data,
        input  rd_available, rd_data, busy, overrun,
        input  sd_req, sd_address, sd_length
    );

endinterface

// File: rtl/video_burst_reader_burst_splitter.sv
// Combinational: size of the next burst, clipped to the words left in the current SDRAM page.
// Zero latency, no state.
module video_burst_reader_burst_splitter #(
    parameter int PAGE_WORDS = 256,
    parameter int PAGE_BITS  = $clog2(PAGE_WORDS)
) (
    input  logic [PAGE_BITS-1:0] offset_i,
    input  logic [8:0]           remaining_i,
    output logic [8:0]           seg_o
);
    logic [9:0] room;
    logic [9:0] rem_ext;

    // 10-bit compare: room reaches PAGE_WORDS itself when the offset is zero.
    always_comb begin
        room    = 10'(PAGE_WORDS) - {{(10-PAGE_BITS){1'b0}}, offset_i};
        rem_ext = {1'b0, remaining_i};
        seg_o   = (rem_ext < room) ? remaining_i : room[8:0];
    end

endmodule

// File: rtl/video_burst_reader.sv
// Splits one row-preload request into page-aligned SDRAM bursts, one outstanding at a time.
// Returned words are forwarded with exactly one cycle of latency; the command holds until sd_ack.
module video_burst_reader
    import video_burst_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32,
    parameter int PAGE_WORDS = PAGE_WORDS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    video_burst_reader_if.master bus
);
    localparam int PAGE_BITS = $clog2(PAGE_WORDS);

    vbr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [8:0]            remaining_q, remaining_d;
    logic [8:0]            seg_count_q, seg_count_d;
    logic                  overrun_q, overrun_d;
    logic                  rd_available_q, rd_available_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic [8:0]            seg;
    logic                  word_vld;

    video_burst_reader_burst_splitter #(
        .PAGE_WORDS (PAGE_WORDS),
        .PAGE_BITS  (PAGE_BITS)
    ) u_splitter (
        .offset_i    (addr_q[PAGE_BITS-1:0]),
        .remaining_i (remaining_q),
        .seg_o       (seg)
    );

    // Words arriving outside a data phase belong to nobody and are dropped.
    assign word_vld = bus.sd_data_valid && (state_q == VBR_WAIT);

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        remaining_d    = remaining_q;
        seg_count_d    = seg_count_q;
        overrun_d      = overrun_q;
        rd_available_d = word_vld;
        rd_data_d      = rd_data_q;

        if (word_vld) begin
            rd_data_d = bus.sd_data;
        end

        if (bus.rd_request && (state_q != VBR_IDLE)) begin
            overrun_d = TRUE;
        end

        case (state_q)
            VBR_IDLE: begin
                if (bus.rd_request && (bus.rd_burst_length != 9'd0)) begin
                    addr_d      = bus.rd_address;
                    remaining_d = bus.rd_burst_length;
                    state_d     = VBR_ISSUE;
                end
            end
            VBR_ISSUE: begin
                if (bus.sd_ack) begin
                    seg_count_d = seg;
                    state_d     = VBR_WAIT;
                end
            end
            VBR_WAIT: begin
                if (word_vld) begin
                    seg_count_d = seg_count_q - 9'd1;
                    remaining_d = remaining_q - 9'd1;
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    if (seg_count_q == 9'd1) begin
                        state_d = (remaining_q == 9'd1) ? VBR_IDLE : VBR_ISSUE;
                    end
                end
            end
            default: begin
                state_d = VBR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= VBR_IDLE;
            addr_q         <= '0;
            remaining_q    <= '0;
            seg_count_q    <= '0;
            overrun_q      <= FALSE;
            rd_available_q <= FALSE;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            remaining_q    <= remaining_d;
            seg_count_q    <= seg_count_d;
            overrun_q      <= overrun_d;
            rd_available_q <= rd_available_d;
            rd_data_q      <= rd_data_d;
        end
    end

    // Command fields come straight from held state, so they stay stable until acked.
    assign bus.sd_req       = (state_q == VBR_ISSUE);
    assign bus.sd_address   = addr_q;
    assign bus.sd_length    = (state_q == VBR_ISSUE) ? seg : 9'd0;
    assign bus.busy         = (state_q != VBR_IDLE);
    assign bus.overrun      = overrun_q;
    assign bus.rd_available = rd_available_q;
    assign bus.rd_data      = rd_data_q;

endmodule

// File: tb/tb_video_burst_reader.sv
// Self-checking bench: the bench acts as SDRAM controller and checks commands and the word stream.
module tb_video_burst_reader;
    import video_burst_reader_pkg::*;

    localparam int AW = 23;
    localparam int DW = 32;
    localparam int PW = 256;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    video_burst_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) vbr ();

    video_burst_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .PAGE_WORDS (PW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vbr)
    );

    int n_checks  = 0;
    int n_fail    = 0;
    int cycle     = 0;
    int delivered = 0;
    bit exp_ovr   = 1'b0;

    typedef struct {
        logic [DW-1:0] dat;
        int            stamp;
    } word_t;
    word_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Stream monitor: every strobe must match the oldest word handed out, one clock later.
    always @(negedge clk) begin
        word_t w;
        if (vbr.rd_available) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rd_available", vbr.rd_available, 1'b0);
            end else begin
                w = exp_q.pop_front();
                chk("rd_data", vbr.rd_data, w.dat);
                chk("rd_latency", cycle - w.stamp, 1);
                delivered++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // Called at a negedge. abort_after >= 0 returns right after that many words.
    task automatic run_xfer(input logic [AW-1:0] a, input int len, input bit overlap,
                            input int abort_after);
        logic [AW-1:0] ca[$];
        int            cl[$];
        int unsigned   am;
        int            r, room, s, total;
        bit            got;

        am = a;
        r  = len;
        while (r > 0) begin
            room = PW - int'(am % PW);
            s    = (r < room) ? r : room;
            ca.push_back(AW'(am));
            cl.push_back(s);
            am = (am + s) % (1 << AW);
            r -= s;
        end

        delivered           = 0;
        vbr.rd_request      = 1'b1;
        vbr.rd_address      = a;
        vbr.rd_burst_length = len[8:0];
        @(negedge clk);
        vbr.rd_request = 1'b0;
        chk("busy_after_req", vbr.busy, len != 0);

        total = 0;
        for (int c = 0; c < ca.size(); c++) begin
            got = 1'b0;
            for (int i = 0; i < 64 && !got; i++) begin
                if (vbr.sd_req) got = 1'b1;
                else @(negedge clk);
            end
            chk("sd_req_seen", got, 1'b1);
            if (!got) return;
            chk("sd_address", vbr.sd_address, ca[c]);
            chk("sd_length", vbr.sd_length, cl[c]);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk("hold_sd_req", vbr.sd_req, 1'b1);
                chk("hold_sd_address", vbr.sd_address, ca[c]);
                chk("hold_sd_length", vbr.sd_length, cl[c]);
            end
            vbr.sd_ack = 1'b1;
            @(negedge clk);
            vbr.sd_ack = 1'b0;
            chk("sd_req_drop", vbr.sd_req, 1'b0);

            for (int k = 0; k < cl[c]; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                vbr.sd_data_valid = 1'b1;
                vbr.sd_data       = $urandom;
                exp_q.push_back('{dat: vbr.sd_data, stamp: cycle});
                if (overlap && c == 0 && k == cl[c] / 2) begin
                    vbr.rd_request      = 1'b1;
                    vbr.rd_address      = AW'($urandom);
                    vbr.rd_burst_length = 9'($urandom_range(1, 511));
                    exp_ovr             = 1'b1;
                end
                @(negedge clk);
                vbr.sd_data_valid = 1'b0;
                vbr.rd_request    = 1'b0;
                total++;
                if (total == abort_after) return;
            end
            chk("busy_after_segment", vbr.busy, c != ca.size() - 1);
        end

        @(negedge clk);
        chk("words_delivered", delivered, len);
        chk("queue_drained", exp_q.size(), 0);
        chk("overrun", vbr.overrun, exp_ovr);
        repeat (3) begin
            @(negedge clk);
            chk("no_extra_sd_req", vbr.sd_req, 1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_available"}, vbr.rd_available, 1'b0);
        chk({tag, "_rd_data"}, vbr.rd_data, 0);
        chk({tag, "_busy"}, vbr.busy, 1'b0);
        chk({tag, "_overrun"}, vbr.overrun, 1'b0);
        chk({tag, "_sd_req"}, vbr.sd_req, 1'b0);
        chk({tag, "_sd_address"}, vbr.sd_address, 0);
        chk({tag, "_sd_length"}, vbr.sd_length, 0);
    endtask

    initial begin
        logic [AW-1:0] ra;

        vbr.rd_request      = 1'b0;
        vbr.rd_address      = '0;
        vbr.rd_burst_length = '0;
        vbr.sd_ack          = 1'b0;
        vbr.sd_data_valid   = 1'b0;
        vbr.sd_data         = '0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        run_xfer(23'h000100, 80, 1'b0, -1);
        run_xfer(23'h0000F0, 80, 1'b0, -1);
        run_xfer(23'h7FFFF0, 32, 1'b0, -1);

        vbr.rd_request      = 1'b1;
        vbr.rd_address      = 23'h000040;
        vbr.rd_burst_length = 9'd0;
        @(negedge clk);
        vbr.rd_request = 1'b0;
        repeat (4) begin
            chk("len0_busy", vbr.busy, 1'b0);
            chk("len0_sd_req", vbr.sd_req, 1'b0);
            @(negedge clk);
        end

        run_xfer(23'h000100, 80, 1'b1, -1);

        run_xfer(23'h000100, 80, 1'b0, 40);
        #2 reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        chk("words_before_abort", delivered, 40);
        exp_q.delete();
        exp_ovr = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        vbr.sd_data_valid = 1'b1;
        vbr.sd_data       = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            chk("stray_rd_available", vbr.rd_available, 1'b0);
            chk("stray_busy", vbr.busy, 1'b0);
        end
        vbr.sd_data_valid = 1'b0;
        @(negedge clk);
        run_xfer(23'h000200, 20, 1'b0, -1);

        run_xfer(23'h000000, 511, 1'b0, -1);

        for (int n = 0; n < 8; n++) begin
            ra = AW'($urandom);
            if ($urandom_range(0, 1) == 1) ra[7:0] = 8'($urandom_range(200, 255));
            run_xfer(ra, $urandom_range(1, 511), 1'($urandom_range(0, 1)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_burst_reader.md
Name: video_burst_reader

Overview:
- Read-side SDRAM port adapter directly upstream of the video controller.
- Accepts one row-preload request: start address plus burst length, up to 511 words.
- Splits the request into SDRAM-page-aligned bursts, issues them to the SDRAM controller's command interface, and forwards the returned words in order as the rd_available/rd_data stream the video controller writes into its row buffer.

Parameters:
ADDR_WIDTH, 23, word address width (shared with video controller rd_address)
DATA_WIDTH, 32, word width (one char+attribute word)
PAGE_WORDS, 256, SDRAM page size in words; power of two; a burst never crosses a page

Ports:
clk  in  1  system clock (108 MHz pixel clock domain)
reset  in  1  asynchronous, active-low reset
rd_request  in  1  one-cycle pulse; latch rd_address/rd_burst_length
rd_address  in  ADDR_WIDTH  first word address of request
rd_burst_length  in  9  words requested (0..511)
rd_available  out  1  one-cycle strobe per delivered word
rd_data  out  DATA_WIDTH  delivered word, valid while rd_available=1
busy  out  1  request in progress
overrun  out  1  sticky: rd_request arrived while busy
sd_req  out  1  burst command valid
sd_ack  in  1  controller accepts command when sd_req&sd_ack
sd_address  out  ADDR_WIDTH  burst start address
sd_length  out  9  burst word count (1..PAGE_WORDS)
sd_data_valid  in  1  returned word strobe from controller
sd_data  in  DATA_WIDTH  returned word

Behaviour:
- Reset (asynchronous, active-low): state IDLE. rd_available=0, rd_data=0, busy=0, overrun=0, sd_req=0, sd_address=0, sd_length=0. All counters are cleared.
- Reset mid-burst: everything is abandoned immediately. Late sd_data_valid words after release are ignored while in IDLE.
- IDLE: on rd_request with length>0, latch addr=rd_address and remaining=length, set busy=1, go to ISSUE next cycle. On rd_request with length=0, nothing happens: busy stays 0 and no command is issued.
- ISSUE:
  - seg = min(remaining, PAGE_WORDS - (addr mod PAGE_WORDS)).
  - Drive sd_req=1, sd_address=addr, sd_length=seg.
  - Hold sd_req and all command fields stable until sd_ack. On the ack cycle, drop sd_req, load seg_count=seg, go to WAIT_DATA.
- WAIT_DATA:
  - Each sd_data_valid: seg_count-1, remaining-1, addr+1 (mod 2^ADDR_WIDTH).
  - When the last word of the segment arrives: if remaining becomes 0, go to IDLE and set busy=0 the same cycle. Otherwise go to ISSUE for the next segment.
  - Only one command is outstanding at a time; the next segment is issued only after the current segment's data is complete.
- Data path:
  - rd_available = sd_data_valid registered; rd_data = sd_data registered. Fixed latency of exactly 1 clk.
  - Words are delivered in address order with no gaps inserted beyond the controller's own.
  - sd_data_valid outside WAIT_DATA is dropped and not forwarded.
- Address wrap: addr increments modulo 2^ADDR_WIDTH. Because 2^ADDR_WIDTH is a multiple of PAGE_WORDS, the top page ends exactly at the wrap, so a segment never straddles it.
- rd_request while busy: the request is ignored, the current transfer continues unaffected, and overrun is set to 1. overrun stays set until reset.
- rd_request and final-word completion in the same cycle: the request counts as busy and is dropped with overrun set. The video controller's preload spacing (one per 20 lines) guarantees this never occurs in normal operation.
- Width rules:
  - seg computed in 10 bits before comparison; page offset = addr[log2(PAGE_WORDS)-1:0].
  - remaining and seg_count are 9 bits.

Decomposition:
- Shared package/include holds:
  - state encodings VBR_IDLE=0, VBR_ISSUE=1, VBR_WAIT=2;
  - TRUE/FALSE constants from the existing constants include;
  - PAGE_WORDS default.
- One natural sub-module: burst_splitter. It is combinational: (addr, remaining) -> seg. It is kept separate so it can be unit-checked exhaustively over page offsets.

Test Plan:
- Aligned single segment: rd_request addr=0x000100, len=80, sd_ack after 3 cycles -> one command (0x000100, 80) held stable for 3 cycles; 80 rd_available strobes each 1 clk after sd_data_valid; busy falls with the 80th word.
- Page-crossing: addr=0x0000F0, len=80 -> commands (0x0000F0, 16) then (0x000100, 64); second sd_req only after the 16th word; data order preserved.
- Top-of-memory wrap: addr=0x7FFFF0, len=32 -> commands (0x7FFFF0, 16) then (0x000000, 16).
- Length zero and overlap: len=0 -> no sd_req, busy stays 0. A request during an active 80-word burst -> overrun=1, transfer completes with exactly 80 words.
- Reset mid-burst: assert reset after 40 of 80 words -> all outputs 0 asynchronously. Stray sd_data_valid after release -> no rd_available. A new request then proceeds normally.
- Max length: addr=0x000000, len=511 -> segments 256, 255; exactly 511 words delivered.
